// File: rtl/tk_mem_pkg.sv
// Shared encodings for the memory request arbiter: memory-controller ops,
// data-side op codes, arbiter FSM states and requester identity.
package tk_mem_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_op_e;

  typedef enum logic [1:0] {
    DOP_ILL_00 = 2'b00,
    DOP_READ   = 2'b01,
    DOP_WRITE  = 2'b10,
    DOP_ILL_11 = 2'b11
  } d_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester, response and memory-controller signals of the arbiter.
// slave = arbiter side, master = requesters plus memory controller.
interface mem_req_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_done;
  logic                  i_err;
  logic                  d_req;
  logic [1:0]            d_op;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_done;
  logic                  d_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            mem_op;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  ready;
  logic                  tx_done;
  logic                  rd_valid;
  logic                  timeout_err;

  modport master (
    output i_req, i_addr, d_req, d_op, d_addr, d_wdata,
    output mem_rdata, ready, tx_done, rd_valid,
    input  i_gnt, i_done, i_err, d_gnt, d_done, d_err, rsp_rdata,
    input  mem_op, cpu_addr, mem_wdata, timeout_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_op, d_addr, d_wdata,
    input  mem_rdata, ready, tx_done, rd_valid,
    output i_gnt, i_done, i_err, d_gnt, d_done, d_err, rsp_rdata,
    output mem_op, cpu_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between instruction and data requesters.
// The pick is combinational; the last winner is registered on upd.
module rr_arb2
  import tk_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_inst,
  input  logic   req_data,
  input  logic   upd,
  input  owner_e upd_owner,
  output owner_e pick_c
);

  owner_e last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_I;
    end else if (upd) begin
      last_q <= upd_owner;
    end
  end

  // On a tie the side that did not win last time goes next.
  always_comb begin
    pick_c = OWN_I;
    if (req_data && (!req_inst || last_q == OWN_I)) begin
      pick_c = OWN_D;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction-fill and data requests onto one memory controller:
// grant, one-cycle issue, wait for completion or timeout, one-cycle response.
module mem_req_arbiter
  import tk_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst_n,
  mem_req_arbiter_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                pick_c;
  logic                  arb_upd_c;
  logic                  is_rd_q, is_rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  mem_op_e               mem_op_q, mem_op_d;
  logic                  i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic                  i_done_q, i_done_d, i_err_q, i_err_d;
  logic                  d_done_q, d_done_d, d_err_q, d_err_d;
  logic                  tout_q, tout_d;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_inst (bus.i_req),
    .req_data (bus.d_req),
    .upd      (arb_upd_c),
    .upd_owner(owner_q),
    .pick_c   (pick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_I;
      is_rd_q  <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_op_q <= MEM_NOP;
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      i_done_q <= 1'b0;
      i_err_q  <= 1'b0;
      d_done_q <= 1'b0;
      d_err_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      is_rd_q  <= is_rd_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_op_q <= mem_op_d;
      i_gnt_q  <= i_gnt_d;
      d_gnt_q  <= d_gnt_d;
      i_done_q <= i_done_d;
      i_err_q  <= i_err_d;
      d_done_q <= d_done_d;
      d_err_q  <= d_err_d;
      tout_q   <= tout_d;
    end
  end

  // Next-state and next-output logic; outputs are the registered copies.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    is_rd_d   = is_rd_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_op_d  = MEM_NOP;
    i_gnt_d   = i_gnt_q;
    d_gnt_d   = d_gnt_q;
    i_done_d  = 1'b0;
    i_err_d   = 1'b0;
    d_done_d  = 1'b0;
    d_err_d   = 1'b0;
    tout_d    = tout_q;
    arb_upd_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ready && (bus.i_req || bus.d_req)) begin
          owner_d = pick_c;
          rdata_d = '0;
          cnt_d   = '0;
          if (pick_c == OWN_D) begin
            d_gnt_d = 1'b1;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            case (d_op_e'(bus.d_op))
              DOP_READ: begin
                mem_op_d = MEM_READ;
                is_rd_d  = 1'b1;
                state_d  = ST_ISSUE;
              end
              DOP_WRITE: begin
                mem_op_d = MEM_WRITE;
                is_rd_d  = 1'b0;
                state_d  = ST_ISSUE;
              end
              // Illegal op: answer with an error, never touch the controller.
              default: begin
                is_rd_d  = 1'b0;
                d_done_d = 1'b1;
                d_err_d  = 1'b1;
                state_d  = ST_RESP;
              end
            endcase
          end else begin
            i_gnt_d  = 1'b1;
            addr_d   = bus.i_addr;
            wdata_d  = '0;
            mem_op_d = MEM_READ;
            is_rd_d  = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        if (is_rd_q && bus.rd_valid) begin
          rdata_d = bus.mem_rdata;
        end
        // A completion in the final counted cycle beats the timeout.
        if (bus.tx_done) begin
          state_d  = ST_RESP;
          i_done_d = (owner_q == OWN_I);
          d_done_d = (owner_q == OWN_D);
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_RESP;
          i_done_d = (owner_q == OWN_I);
          i_err_d  = (owner_q == OWN_I);
          d_done_d = (owner_q == OWN_D);
          d_err_d  = (owner_q == OWN_D);
          tout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d   = ST_IDLE;
        i_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        arb_upd_c = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.i_gnt       = i_gnt_q;
  assign bus.d_gnt       = d_gnt_q;
  assign bus.i_done      = i_done_q;
  assign bus.i_err       = i_err_q;
  assign bus.d_done      = d_done_q;
  assign bus.d_err       = d_err_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.mem_op      = mem_op_q;
  assign bus.cpu_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed per-cycle vectors for mem_req_arbiter (TIMEOUT_CYCLES=8), plus a
// hand-driven asynchronous reset in the middle of a WAIT.
module tb_mem_req_arbiter;

  localparam logic [63:0] I_ADDR = 64'h1000;

  typedef struct {
    string       tag;
    logic        rst_n, i_req, d_req;
    logic [1:0]  d_op;
    logic        ready, tx_done, rd_valid;
    logic [31:0] mem_rdata;
    logic [63:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  e_gnt;   // {i_gnt, d_gnt}
    logic [3:0]  e_de;    // {i_done, i_err, d_done, d_err}
    logic [1:0]  e_mop;
    logic        e_to;
    logic        chk_rsp;
    logic [31:0] e_rsp;
    logic [63:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  logic clk;
  logic rst_n;
  vec_t vecs[$];
  logic [63:0] cur_d_addr;
  logic [31:0] cur_d_wdata;
  int n_vec;
  int n_err;

  mem_req_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) bus ();

  mem_req_arbiter #(
    .ADDR_WIDTH    (64),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input string tag, input int r, input int ii, input int dd, input int op,
                     input int rdy, input int tx, input int rv, input logic [31:0] rdata,
                     input int eg, input int ede, input int emo, input int eto,
                     input int crsp, input logic [31:0] ersp);
    vec_t v;
    v.tag = tag;
    v.rst_n = 1'(r);
    v.i_req = 1'(ii);
    v.d_req = 1'(dd);
    v.d_op = 2'(op);
    v.ready = 1'(rdy);
    v.tx_done = 1'(tx);
    v.rd_valid = 1'(rv);
    v.mem_rdata = rdata;
    v.d_addr = cur_d_addr;
    v.d_wdata = cur_d_wdata;
    v.e_gnt = 2'(eg);
    v.e_de = 4'(ede);
    v.e_mop = 2'(emo);
    v.e_to = 1'(eto);
    v.chk_rsp = 1'(crsp);
    v.e_rsp = ersp;
    v.e_addr = v.e_gnt[0] ? cur_d_addr : I_ADDR;
    v.e_wdata = cur_d_wdata;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let the edge pass, then compare.
  task automatic apply(input vec_t v);
    logic [8:0] got_ctl;
    logic [8:0] exp_ctl;
    logic bad;
    rst_n = v.rst_n;
    bus.i_req = v.i_req;
    bus.i_addr = I_ADDR;
    bus.d_req = v.d_req;
    bus.d_op = v.d_op;
    bus.d_addr = v.d_addr;
    bus.d_wdata = v.d_wdata;
    bus.ready = v.ready;
    bus.tx_done = v.tx_done;
    bus.rd_valid = v.rd_valid;
    bus.mem_rdata = v.mem_rdata;
    @(posedge clk);
    #1;
    got_ctl = {bus.i_gnt, bus.d_gnt, bus.i_done, bus.i_err, bus.d_done, bus.d_err,
               bus.mem_op, bus.timeout_err};
    exp_ctl = {v.e_gnt, v.e_de, v.e_mop, v.e_to};
    bad = (got_ctl !== exp_ctl);
    if (v.chk_rsp && bus.rsp_rdata !== v.e_rsp) bad = 1'b1;
    if (v.e_mop != 2'b00 && bus.cpu_addr !== v.e_addr) bad = 1'b1;
    if (v.e_mop == 2'b10 && bus.mem_wdata !== v.e_wdata) bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: gnt/done/err/op/to got %b exp %b, rsp got %h exp %h, addr got %h exp %h, wdata got %h exp %h",
               v.tag, got_ctl, exp_ctl, bus.rsp_rdata, v.e_rsp, bus.cpu_addr, v.e_addr,
               bus.mem_wdata, v.e_wdata);
    end
  endtask

  task automatic run_vecs();
    foreach (vecs[k]) apply(vecs[k]);
    vecs.delete();
  endtask

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", name, got, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_req = 1'b0;
    bus.i_addr = I_ADDR;
    bus.d_req = 1'b0;
    bus.d_op = 2'b00;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.ready = 1'b0;
    bus.tx_done = 1'b0;
    bus.rd_valid = 1'b0;
    bus.mem_rdata = '0;
    cur_d_addr = 64'h0;
    cur_d_wdata = 32'h0;

    add("reset", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 1, 0);
    // Instruction read; completion in the fourth WAIT cycle.
    add("i_grant", 1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0);
    add("i_issue_ignores_tx", 1, 1, 0, 0, 0, 1, 1, 32'h11111111, 2'b10, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add("i_wait", 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0);
    add("i_done", 1, 1, 0, 0, 0, 1, 1, 32'hDEADBEEF, 2'b10, 4'b1000, 0, 0, 1, 32'hDEADBEEF);
    add("i_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Simultaneous requests from reset: D, then I, then D again.
    add("reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cur_d_addr = 64'h2000;
    add("tie_d_first", 1, 1, 1, 2'b01, 1, 0, 0, 0, 2'b01, 0, 2'b01, 0, 0, 0);
    add("tie_d_issue", 1, 1, 1, 2'b01, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
    add("tie_d_done", 1, 1, 1, 2'b01, 0, 1, 1, 32'hCAFEF00D, 2'b01, 4'b0010, 0, 0, 1, 32'hCAFEF00D);
    add("tie_no_grant_in_resp", 1, 1, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("tie_i_second", 1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0);
    add("tie_i_issue", 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0);
    add("tie_i_done", 1, 1, 0, 0, 0, 1, 0, 0, 2'b10, 4'b1000, 0, 0, 0, 0);
    add("tie_i_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cur_d_addr = 64'h3000;
    cur_d_wdata = 32'h12345678;
    add("tie2_d_write", 1, 1, 1, 2'b10, 1, 0, 0, 0, 2'b01, 0, 2'b10, 0, 0, 0);
    add("wr_issue", 1, 0, 1, 2'b10, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
    add("wr_done", 1, 0, 1, 2'b10, 0, 1, 0, 0, 2'b01, 4'b0010, 0, 0, 0, 0);
    add("wr_idle", 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Illegal op, first held off by ready=0.
    add("ill_not_ready", 1, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("ill_resp", 1, 0, 1, 2'b11, 1, 0, 0, 0, 2'b01, 4'b0011, 0, 0, 1, 0);
    add("ill_idle", 1, 0, 0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // D read that never completes: abort after 8 WAIT cycles.
    cur_d_addr = 64'h4000;
    add("to_grant", 1, 0, 1, 2'b01, 1, 0, 0, 0, 2'b01, 0, 2'b01, 0, 0, 0);
    add("to_issue", 1, 0, 1, 2'b01, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) add("to_wait", 1, 0, 1, 2'b01, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);
    add("to_abort", 1, 0, 1, 2'b01, 0, 0, 0, 0, 2'b01, 4'b0011, 0, 1, 0, 0);
    add("to_sticky", 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Completion in the last counted cycle wins over the timeout.
    add("late_grant", 1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 2'b01, 1, 0, 0);
    add("late_issue", 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 1, 0, 0);
    for (int k = 0; k < 7; k++) add("late_wait", 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 1, 0, 0);
    add("late_done", 1, 1, 0, 0, 0, 1, 1, 32'h0BADF00D, 2'b10, 4'b1000, 0, 1, 1, 32'h0BADF00D);
    add("late_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Requester drops mid-transaction; done still arrives.
    cur_d_addr = 64'h5000;
    add("drop_grant", 1, 0, 1, 2'b01, 1, 0, 0, 0, 2'b01, 0, 2'b01, 1, 0, 0);
    add("drop_issue", 1, 0, 0, 2'b01, 0, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0);
    add("drop_wait_rdata", 1, 0, 0, 0, 0, 0, 1, 32'h55AA55AA, 2'b01, 0, 0, 1, 0, 0);
    add("drop_done", 1, 0, 0, 0, 0, 1, 0, 0, 2'b01, 4'b0010, 0, 1, 1, 32'h55AA55AA);
    add("drop_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Start an I read and park it in WAIT.
    add("rst_grant", 1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 2'b01, 1, 0, 0);
    add("rst_issue", 1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 0, 1, 0, 0);
    add("rst_wait", 1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 0, 1, 0, 0);
    run_vecs();

    // Asynchronous reset between edges must clear every output at once.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        192'({bus.i_gnt, bus.d_gnt, bus.i_done, bus.i_err, bus.d_done, bus.d_err, bus.mem_op,
              bus.timeout_err, bus.rsp_rdata, bus.cpu_addr, bus.mem_wdata}),
        192'(0));

    add("rst_hold_tx_ignored", 0, 1, 0, 0, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0);
    add("rst_hold2", 0, 1, 0, 0, 1, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0);
    add("rst_regrant", 1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 0);
    add("rst_re_issue", 1, 1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0);
    add("rst_re_done", 1, 1, 0, 0, 1, 1, 1, 32'h600DCAFE, 2'b10, 4'b1000, 0, 0, 1, 32'h600DCAFE);
    add("rst_re_idle", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_vecs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
